// File: rtl/video_stream_source.sv
`default_nettype none
//============================================================================
// Module      : video_stream_source
// Description : Raster timing generator that paces an upstream pixel stream
//               into active/blanking video with en/hsync/vsync framing.
//               Optional macro VIDEO_STREAM_SOURCE_TEST_PATTERN_EN adds a
//               test_mode input that replaces upstream pixels with a pattern.
// Revision    : 1.0 - initial release
//============================================================================

`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

module video_stream_source #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   src_valid,
    input  logic [`PIXEL_SIZE-1:0] src_data,
`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
    input  logic                   test_mode,
`endif
    output logic                   src_ready,
    output logic                   en,
    output logic                   hsync,
    output logic                   vsync,
    output logic [`PIXEL_SIZE-1:0] data,
    output logic                   busy,
    output logic                   underflow
);

    localparam int unsigned c_LINE_CYCLES   = H_ACTIVE + H_BLANK;
    localparam int unsigned c_VBLANK_CYCLES = V_BLANK * c_LINE_CYCLES;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [15:0]            r_x;
    logic [15:0]            w_x_nxt;
    logic [15:0]            r_y;
    logic [15:0]            w_y_nxt;
    logic [31:0]            r_cnt;
    logic [31:0]            w_cnt_nxt;
    logic                   w_start;
    logic                   w_pattern;
    logic                   w_missing;
    logic [`PIXEL_SIZE-1:0] w_pixel;

    logic                   r_en;
    logic                   r_hsync;
    logic                   r_vsync;
    logic [`PIXEL_SIZE-1:0] r_data;
    logic                   r_underflow;

`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
    logic [7:0]             r_frame_cnt;

    assign w_pattern = test_mode;
`else
    assign w_pattern = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Raster state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x     <= 16'd0;
            r_y     <= 16'd0;
            r_cnt   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt times both blanking intervals; r_x only advances while ACTIVE.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_ACTIVE;
                    w_x_nxt     = 16'd0;
                    w_y_nxt     = 16'd0;
                    w_cnt_nxt   = 32'd0;
                    w_start     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (r_x == 16'(H_ACTIVE - 1)) begin
                    w_state_nxt = S_HBLANK;
                    w_x_nxt     = 16'd0;
                    w_cnt_nxt   = 32'd0;
                end else begin
                    w_x_nxt = r_x + 16'd1;
                end
            end
            S_HBLANK: begin
                if (r_cnt == 32'(H_BLANK - 1)) begin
                    w_cnt_nxt = 32'd0;
                    if (r_y < 16'(V_ACTIVE - 1)) begin
                        w_y_nxt     = r_y + 16'd1;
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_state_nxt = S_VBLANK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_VBLANK: begin
                if (r_cnt == 32'(c_VBLANK_CYCLES - 1)) begin
                    w_cnt_nxt   = 32'd0;
                    w_y_nxt     = 16'd0;
                    w_state_nxt = run ? S_ACTIVE : S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel selection
    // ------------------------------------------------------------------
    always_comb begin
        w_pixel = '0;
        if (r_state == S_ACTIVE) begin
`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
            if (w_pattern) begin
                w_pixel = `PIXEL_SIZE'({r_frame_cnt, r_y[7:0], r_x[7:0]});
            end else if (src_valid) begin
                w_pixel = src_data;
            end
`else
            if (src_valid) begin
                w_pixel = src_data;
            end
`endif
        end
    end

    // A missing pixel never stalls timing; it is blanked and flagged.
    assign w_missing = (r_state == S_ACTIVE) && !src_valid && !w_pattern;

    // ------------------------------------------------------------------
    // Registered video outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en        <= 1'b0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
            r_data      <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_en    <= (r_state == S_ACTIVE);
            r_hsync <= (r_state == S_HBLANK) && (r_cnt == 32'd0);
            r_vsync <= (r_state == S_VBLANK) && (r_cnt == 32'd0);
            r_data  <= w_pixel;
            if (w_missing) begin
                r_underflow <= 1'b1;
            end else if (w_start) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
    // Advances on the same edge that raises vsync.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= 8'd0;
        end else if ((r_state == S_VBLANK) && (r_cnt == 32'd0)) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end
`endif

    assign src_ready = (r_state == S_ACTIVE) && !w_pattern;
    assign busy      = (r_state != S_IDLE);
    assign en        = r_en;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign data      = r_data;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_video_stream_source.sv
`default_nettype none
//============================================================================
// Module      : tb_video_stream_source
// Description : Directed bench for video_stream_source with a 4x3 raster,
//               2-cycle hblank and 2-line vblank (30-cycle frame).
// Revision    : 1.0 - initial release
//============================================================================

`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

module tb_video_stream_source;

    localparam int c_HA = 4;
    localparam int c_HB = 2;
    localparam int c_VA = 3;
    localparam int c_VB = 2;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   run;
    logic                   src_valid;
    logic [`PIXEL_SIZE-1:0] src_data;
`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
    logic                   test_mode;
`endif
    logic                   src_ready;
    logic                   en;
    logic                   hsync;
    logic                   vsync;
    logic [`PIXEL_SIZE-1:0] data;
    logic                   busy;
    logic                   underflow;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    always #5 clk = ~clk;

    video_stream_source #(
        .H_ACTIVE (c_HA),
        .H_BLANK  (c_HB),
        .V_ACTIVE (c_VA),
        .V_BLANK  (c_VB)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .src_valid (src_valid),
        .src_data  (src_data),
`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .src_ready (src_ready),
        .en        (en),
        .hsync     (hsync),
        .vsync     (vsync),
        .data      (data),
        .busy      (busy),
        .underflow (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // k counts rising edges since the edge that first sampled run high.
    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    // Upstream pixel for the cycle following edge k is x+1 (6-cycle line).
    task automatic drive_src();
        src_data = `PIXEL_SIZE'(((k + 5) % 6) + 1);
    endtask

    // Hand-derived raster: ACTIVE on frame cycles 1-4,7-10,13-16; en one later;
    // hsync on 6,12,18; vsync on 20; busy on 1..30 of each frame.
    task automatic check_cycle(input int nframes, input int hole);
        bit in_f;
        bit act;
        bit e;
        int j;
        int d;
        in_f = (k >= 1) && (k <= 30 * nframes);
        j    = ((k - 1) % 30) + 1;
        act  = in_f && (j <= 16) && (((j - 1) % 6) < 4);
        e    = in_f && (j >= 2) && (j <= 17) && (((j - 2) % 6) < 4);
        d    = (e && (k != hole)) ? (((j - 2) % 6) + 1) : 0;
        chk($sformatf("en@%0d", k), en, e);
        chk($sformatf("data@%0d", k), data, d);
        chk($sformatf("hsync@%0d", k), hsync, in_f && (j == 6 || j == 12 || j == 18));
        chk($sformatf("vsync@%0d", k), vsync, in_f && (j == 20));
        chk($sformatf("busy@%0d", k), busy, in_f);
        chk($sformatf("src_ready@%0d", k), src_ready, act);
    endtask

    initial begin
        reset_n   = 1'b0;
        run       = 1'b0;
        src_valid = 1'b1;
        src_data  = '0;
`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_en", en, 0);
        chk("rst_data", data, 0);
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", src_ready, 0);
        chk("rst_uf", underflow, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single run pulse, missing pixel at line 1 x=2 (cycle after edge 9).
        k   = 0;
        run = 1'b1;
        drive_src();
        for (int c = 0; c < 32; c++) begin
            tick();
            run = 1'b0;
            check_cycle(1, 10);
            chk($sformatf("uf_a@%0d", k), underflow, (k >= 10));
            src_valid = (k != 9);
            drive_src();
        end

        // run held for two frames, dropped during line 0 of the second.
        k         = 0;
        run       = 1'b1;
        src_valid = 1'b1;
        drive_src();
        for (int c = 0; c < 62; c++) begin
            tick();
            check_cycle(2, -1);
            chk($sformatf("uf_b@%0d", k), underflow, 0);
            if (k == 33) run = 1'b0;
            drive_src();
        end

        // Asynchronous reset in the middle of an active line.
        k   = 0;
        run = 1'b1;
        drive_src();
        repeat (3) begin
            tick();
            drive_src();
        end
        chk("pre_rst_en", en, 1);
        run     = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_en", en, 0);
        chk("arst_data", data, 0);
        chk("arst_hsync", hsync, 0);
        chk("arst_vsync", vsync, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", src_ready, 0);
        chk("arst_uf", underflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_en", en, 0);
            chk("post_rst_busy", busy, 0);
        end
        k   = 0;
        run = 1'b1;
        tick();
        run = 1'b0;
        drive_src();
        chk("restart_busy", busy, 1);
        chk("restart_en", en, 0);
        chk("restart_ready", src_ready, 1);
        tick();
        drive_src();
        chk("restart_en2", en, 1);
        chk("restart_data", data, 1);
        while (k < 31) begin
            tick();
            drive_src();
        end
        chk("restart_idle", busy, 0);

`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
        reset_n = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        test_mode = 1'b1;
        src_valid = 1'b0;
        k         = 0;
        run       = 1'b1;
        for (int c = 0; c < 62; c++) begin
            tick();
            chk($sformatf("tp_ready@%0d", k), src_ready, 0);
            chk($sformatf("tp_uf@%0d", k), underflow, 0);
            if (k == 3)  chk("tp_f0_y0_x1", data, 32'h000001);
            if (k == 47) chk("tp_f1_y2_x3", data, 32'h010203);
            if (k == 33) run = 1'b0;
        end
        test_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
